pixel_sink: RTL and testbench
=============================

# pixel_sink

Receiving end of the drawing-block pixel interface (plot / x / y / colour). It accepts pixel strobes from any drawer, for example the spike renderer, and checks each against the screen bounds. Valid pixels go into a small FIFO. The FIFO drains into a single-port framebuffer write interface with a ready handshake. The block also provides a full-screen clear sweep used at game start and restart.

## Interface
- WIDTH, 160, screen width in pixels
- HEIGHT, 120, screen height in pixels
- FIFO_DEPTH, 4, pixel queue entries (power of two, ≥2)
- CLEAR_COLOUR, 3'b000, colour written by a clear sweep
- clock  in  1  system clock, all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- plot  in  1  pixel strobe from drawer; one pixel per cycle high
- in_x  in  8  pixel column
- in_y  in  8  pixel row
- in_colour  in  3  pixel colour
- busy  out  1  high when a plot this cycle will not be accepted (FIFO full or clear active)
- clear  in  1  request full-screen clear (level sampled each cycle)
- clear_done  out  1  one-cycle pulse after last clear write
- mem_addr  out  15  framebuffer address = y*WIDTH + x
- mem_data  out  3  framebuffer write colour
- mem_we  out  1  write request; held with addr/data until mem_ready
- mem_ready  in  1  framebuffer accepts the write in any cycle where mem_we && mem_ready
- drop_count  out  8  saturating count of rejected pixels

## Operation
- **Accept rule.** A pixel is accepted on an edge when plot=1, busy=0, in_x<WIDTH and in_y<HEIGHT. Accepted pixels are pushed as {addr, colour}.
- **Address.** addr is computed at push as in_y*WIDTH+in_x, truncated to 15 bits. The default geometry gives a maximum of 19199.
- **Drops.** drop_count increments by 1 (saturating at 255) when either of these holds at an edge:
  - plot=1 with an out-of-range coordinate; or
  - plot=1 while busy=1.
- Dropped pixels are never written.
- **FSM states.** IDLE, WRITE, CLEAR.
- **IDLE**
  - clear=1 → CLEAR. This flushes the FIFO and sets the sweep address to 0. Clear has priority over queued pixels.
  - Otherwise, FIFO non-empty → WRITE.
- **WRITE**
  - mem_we=1; mem_addr and mem_data come from the FIFO head.
  - On mem_ready: pop the head. Stay in WRITE if another entry remains after the pop, otherwise go to IDLE.
  - clear=1 in WRITE is not sampled until IDLE is reached. The current write always completes.
- **CLEAR**
  - mem_we=1, mem_addr = sweep address, mem_data = CLEAR_COLOUR.
  - On mem_ready the address increments.
  - On mem_ready at address WIDTH*HEIGHT-1: pulse clear_done on the next cycle and return to IDLE.
  - clear is ignored while in CLEAR. If clear is still high on return to IDLE, a new sweep starts.
- **Idle outputs.** When mem_we=0: mem_addr=0, mem_data=0.
- **FIFO occupancy.**
  - Push and pop on the same edge are allowed; occupancy is unchanged.
  - busy = (occupancy == FIFO_DEPTH) || state==CLEAR.
  - busy is computed from registered state only; it is never combinationally dependent on plot.
- **Reset.** resetn=0 at an edge returns the block to the reset state from any state, including mid-clear or mid-write.
  - Outputs: busy=0, clear_done=0, mem_we=0, mem_addr=0, mem_data=0, drop_count=0.
  - FIFO emptied, state IDLE, sweep address 0.
  - An interrupted clear is not resumed.

## Timing
- **Write latency.** A pixel accepted at edge N gives state WRITE with mem_we=1 for the cycle after edge N+1, provided the FIFO was empty and the state was IDLE.
- **Throughput.** With mem_ready tied high, the block sustains one pixel write per cycle after the initial latency.
- **Handshake.** mem_addr and mem_data are stable while mem_we=1 && mem_ready=0. Stall length is unbounded.
- **Clear duration.** With mem_ready=1, a clear takes WIDTH*HEIGHT write cycles. clear_done is high for exactly one cycle, the cycle after the final write edge. busy falls in that same cycle.
- **Queued writes vs clear.** Writes whose pop edge precedes the CLEAR entry edge reach memory. All remaining entries are discarded without incrementing drop_count.

## Test plan
- **Single write.** Reset, mem_ready=1; plot x=5, y=2, colour=3'b101 for one cycle → one cycle with mem_we=1, mem_addr=325, mem_data=5, two edges after the plot edge; drop_count=0.
- **Bounds.** Plot (160,0), then (0,120), then (159,119) → only address 19199 is written; drop_count=2.
- **Back-pressure.** mem_ready=0; plot 6 consecutive in-range pixels → busy=1 after the 4th push; pixels 5 and 6 are dropped, drop_count=2. Then mem_ready=1 → pixels 1–4 are written in order on 4 consecutive cycles.
- **Clear.** Pulse clear, mem_ready=1 → mem_we=1 for 19200 consecutive cycles with addresses 0..19199 and data 0. clear_done is a single pulse. A plot issued during the sweep increments drop_count.
- **Reset mid-operation.**
  - Assert resetn=0 at sweep address 1000 → next cycle mem_we=0, busy=0, drop_count=0.
  - A subsequent plot (1,1) → address 161 is written.

Source files
------------

// File: rtl/pixel_sink.sv
// pixel_sink: bounds-checks drawer pixel strobes, queues them in a small FIFO and
// drains them to a single-port framebuffer; also runs the full-screen clear sweep.
module pixel_sink #(
    parameter int         WIDTH        = 160,
    parameter int         HEIGHT       = 120,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        plot,
    input  logic [7:0]  in_x,
    input  logic [7:0]  in_y,
    input  logic [2:0]  in_colour,
    output logic        busy,
    input  logic        clear,
    output logic        clear_done,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic [7:0]  drop_count
);

    localparam int               PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [8:0]       WIDTH_L    = 9'(WIDTH);
    localparam logic [8:0]       HEIGHT_L   = 9'(HEIGHT);
    localparam logic [14:0]      WIDTH_M    = 15'(WIDTH);
    localparam logic [14:0]      LAST_ADDR  = 15'(WIDTH * HEIGHT - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   ONE_COUNT  = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    state_t            state, state_next;
    logic [14:0]       fifo_addr   [FIFO_DEPTH];
    logic [2:0]        fifo_colour [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic [14:0]       sweep_addr;
    logic              clear_done_q;
    logic [7:0]        drop_q;
    logic              in_range, push, pop, drop, flush, sweep_last;
    logic [14:0]       push_addr;

    assign in_range   = ({1'b0, in_x} < WIDTH_L) && ({1'b0, in_y} < HEIGHT_L);
    assign busy       = (count == FULL_COUNT) || (state == CLEAR);
    assign push       = plot && !busy && in_range;
    assign drop       = plot && (busy || !in_range);
    assign pop        = (state == WRITE) && mem_ready;
    assign flush      = (state == IDLE) && clear;
    assign sweep_last = (state == CLEAR) && mem_ready && (sweep_addr == LAST_ADDR);
    assign push_addr  = {7'd0, in_y} * WIDTH_M + {7'd0, in_x};
    assign clear_done = clear_done_q;
    assign drop_count = drop_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // WRITE drops back to IDLE only when the pop empties the queue with no same-edge push.
    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_next = CLEAR;
                end else if (count != '0) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                mem_we   = 1'b1;
                mem_addr = fifo_addr[rd_ptr];
                mem_data = fifo_colour[rd_ptr];
                if (mem_ready && (count == ONE_COUNT) && !push) begin
                    state_next = IDLE;
                end
            end
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = sweep_addr;
                mem_data = CLEAR_COLOUR;
                if (sweep_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr]   <= push_addr;
            fifo_colour[wr_ptr] <= in_colour;
        end
    end

    // Entering a clear discards everything still queued, including a same-edge push.
    always_ff @(posedge clock) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sweep_addr   <= '0;
            clear_done_q <= 1'b0;
        end else begin
            clear_done_q <= sweep_last;
            if (flush || sweep_last) begin
                sweep_addr <= '0;
            end else if ((state == CLEAR) && mem_ready) begin
                sweep_addr <= sweep_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_sink.sv
// tb_pixel_sink: directed stimulus with a write scoreboard; a negedge monitor pops
// expected {addr, colour} entries whenever the framebuffer accepts a write.
module tb_pixel_sink;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        plot = 1'b0;
    logic [7:0]  in_x = '0;
    logic [7:0]  in_y = '0;
    logic [2:0]  in_colour = '0;
    logic        clear = 1'b0;
    logic        mem_ready = 1'b0;
    logic        busy, clear_done, mem_we;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic [7:0]  drop_count;

    int          checks = 0;
    int          failures = 0;
    int          done_pulses = 0;
    logic [17:0] exp_q[$];

    pixel_sink dut (
        .clock      (clock),
        .resetn     (resetn),
        .plot       (plot),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .busy       (busy),
        .clear      (clear),
        .clear_done (clear_done),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    // Every accepted framebuffer write must match the next expected entry, in order.
    always @(negedge clock) begin
        logic [17:0] expected;
        if (resetn && mem_we && mem_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write got addr=%0d data=%0d expected no write",
                         mem_addr, mem_data);
            end else begin
                expected = exp_q.pop_front();
                if ({mem_addr, mem_data} !== expected) begin
                    failures++;
                    $display("[TB] FAIL write_entry got addr=%0d data=%0d expected addr=%0d data=%0d",
                             mem_addr, mem_data, expected[17:3], expected[2:0]);
                end
            end
        end
        if (clear_done) begin
            done_pulses++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int x, input int y, input int colour);
        plot      = 1'b1;
        in_x      = 8'(x);
        in_y      = 8'(y);
        in_colour = 3'(colour);
        step();
        plot      = 1'b0;
    endtask

    task automatic resetPhase();
        resetn    = 1'b0;
        plot      = 1'b0;
        clear     = 1'b0;
        mem_ready = 1'b0;
        step();
        step();
        exp_q.delete();
        resetn = 1'b1;
    endtask

    initial begin
        int k;
        #1;
        resetPhase();
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_mem_we", int'(mem_we), 0);
        checkOutput("reset_mem_addr", int'(mem_addr), 0);
        checkOutput("reset_mem_data", int'(mem_data), 0);
        checkOutput("reset_drop_count", int'(drop_count), 0);
        checkOutput("reset_clear_done", int'(clear_done), 0);

        // Single write: lands two edges after the plot edge.
        mem_ready = 1'b1;
        exp_q.push_back({15'd325, 3'd5});
        applyStimulus(5, 2, 5);
        checkOutput("single_no_we_yet", int'(mem_we), 0);
        step();
        checkOutput("single_we", int'(mem_we), 1);
        checkOutput("single_addr", int'(mem_addr), 325);
        checkOutput("single_data", int'(mem_data), 5);
        step();
        checkOutput("single_we_done", int'(mem_we), 0);
        checkOutput("single_drop", int'(drop_count), 0);

        // Bounds: only the bottom-right corner is in range.
        exp_q.push_back({15'd19199, 3'd7});
        applyStimulus(160, 0, 1);
        applyStimulus(0, 120, 2);
        applyStimulus(159, 119, 7);
        repeat (5) step();
        checkOutput("bounds_drop", int'(drop_count), 2);
        checkOutput("bounds_pending", exp_q.size(), 0);

        // Drop counter saturates.
        resetPhase();
        plot = 1'b1;
        in_x = 8'd200;
        in_y = 8'd0;
        repeat (100) step();
        checkOutput("drop_count_100", int'(drop_count), 100);
        repeat (160) step();
        plot = 1'b0;
        checkOutput("drop_saturate", int'(drop_count), 255);

        // Back-pressure: four pushes fill the queue, the next two are dropped.
        resetPhase();
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back({15'(490 + i), 3'(i)});
        end
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(10 + i, 3, i);
            if (i == 3) checkOutput("bp_busy_after3", int'(busy), 0);
            if (i == 4) checkOutput("bp_busy_after4", int'(busy), 1);
        end
        checkOutput("bp_drop", int'(drop_count), 2);
        step();
        step();
        checkOutput("bp_stall_we", int'(mem_we), 1);
        checkOutput("bp_stall_addr", int'(mem_addr), 491);
        checkOutput("bp_stall_data", int'(mem_data), 1);
        mem_ready = 1'b1;
        repeat (3) step();
        checkOutput("bp_fourth_we", int'(mem_we), 1);
        checkOutput("bp_fourth_addr", int'(mem_addr), 494);
        step();
        checkOutput("bp_drained_we", int'(mem_we), 0);
        checkOutput("bp_pending", exp_q.size(), 0);

        // Full clear sweep with a plot dropped mid-sweep.
        resetPhase();
        mem_ready = 1'b1;
        for (int a = 0; a < 19200; a++) begin
            exp_q.push_back({15'(a), 3'd0});
        end
        done_pulses = 0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        checkOutput("clear_busy", int'(busy), 1);
        checkOutput("clear_first_we", int'(mem_we), 1);
        checkOutput("clear_first_addr", int'(mem_addr), 0);
        applyStimulus(1, 1, 3);
        k = 1;
        while (!clear_done && k < 20000) begin
            step();
            k++;
        end
        checkOutput("clear_cycles", k, 19200);
        checkOutput("clear_done_busy", int'(busy), 0);
        step();
        checkOutput("clear_done_low", int'(clear_done), 0);
        checkOutput("clear_done_pulses", done_pulses, 1);
        checkOutput("clear_drop", int'(drop_count), 1);
        checkOutput("clear_after_we", int'(mem_we), 0);
        checkOutput("clear_pending", exp_q.size(), 0);

        // Reset in the middle of a sweep, then a normal write.
        for (int a = 0; a < 1000; a++) begin
            exp_q.push_back({15'(a), 3'd0});
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        applyStimulus(2, 2, 1);
        k = 0;
        while (!(mem_we && mem_addr == 15'd1000) && k < 1100) begin
            step();
            k++;
        end
        checkOutput("mid_reach_1000", int'(mem_addr), 1000);
        checkOutput("mid_drop_before", int'(drop_count), 2);
        resetn = 1'b0;
        step();
        checkOutput("mid_reset_we", int'(mem_we), 0);
        checkOutput("mid_reset_busy", int'(busy), 0);
        checkOutput("mid_reset_drop", int'(drop_count), 0);
        checkOutput("mid_reset_pending", exp_q.size(), 0);
        resetn    = 1'b1;
        mem_ready = 1'b1;
        exp_q.push_back({15'd161, 3'd6});
        applyStimulus(1, 1, 6);
        repeat (6) step();
        checkOutput("post_reset_pending", exp_q.size(), 0);
        checkOutput("post_reset_idle_we", int'(mem_we), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
